// File: rtl/vga_layer_pkg.sv
// ============================================================================
// vga_layer_pkg
// Shared definitions for the VGA layer arbiter:
//   - config register indices (CFG_*)
//   - commit FSM state encoding
//   - PIX_INVALID marker driven by vga_ctrl outside the active area
//   - reset values for the EN and window registers
//   - cfg_regs_t bundle of one complete register set (stage or live)
// Optional feature macro: VGA_LAYER_ARB_BLINK_EN (widens EN to 4 bits so
// that EN[3] can enable L2 blinking).
// ============================================================================
package vga_layer_pkg;

`ifdef VGA_LAYER_ARB_BLINK_EN
    localparam int EN_W = 4;
`else
    localparam int EN_W = 3;
`endif

    localparam logic [2:0] CFG_EN   = 3'd0;
    localparam logic [2:0] CFG_BG   = 3'd1;
    localparam logic [2:0] CFG_X0   = 3'd2;
    localparam logic [2:0] CFG_Y0   = 3'd3;
    localparam logic [2:0] CFG_X1   = 3'd4;
    localparam logic [2:0] CFG_Y1   = 3'd5;
    localparam logic [2:0] CFG_PRIO = 3'd6;
    localparam logic [2:0] CFG_RSVD = 3'd7;

    localparam logic [9:0] PIX_INVALID = 10'h3FF;

    localparam logic [EN_W-1:0] EN_RST = EN_W'(1);
    // X0 > X1 and Y0 > Y1: the overlay window starts out empty.
    localparam logic [9:0] X0_RST = 10'd1;
    localparam logic [9:0] Y0_RST = 10'd1;
    localparam logic [9:0] X1_RST = 10'd0;
    localparam logic [9:0] Y1_RST = 10'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } cfg_state_e;

    typedef struct packed {
        logic [EN_W-1:0] en;
        logic [15:0]     bg;
        logic [9:0]      x0;
        logic [9:0]      y0;
        logic [9:0]      x1;
        logic [9:0]      y1;
        logic            prio;
    } cfg_regs_t;

    localparam cfg_regs_t CFG_RST = '{
        en:   EN_RST,
        bg:   16'h0000,
        x0:   X0_RST,
        y0:   Y0_RST,
        x1:   X1_RST,
        y1:   Y1_RST,
        prio: 1'b0
    };

    // Apply one register write to a register set; unused data bits drop out.
    function automatic cfg_regs_t cfg_apply(input cfg_regs_t r,
                                            input logic [2:0] addr,
                                            input logic [15:0] wd);
        cfg_regs_t n;
        n = r;
        case (addr)
            CFG_EN:   n.en   = wd[EN_W-1:0];
            CFG_BG:   n.bg   = wd;
            CFG_X0:   n.x0   = wd[9:0];
            CFG_Y0:   n.y0   = wd[9:0];
            CFG_X1:   n.x1   = wd[9:0];
            CFG_Y1:   n.y1   = wd[9:0];
            CFG_PRIO: n.prio = wd[0];
            default:  ;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vga_layer_cfg.sv
// ============================================================================
// vga_layer_cfg
// Shadow (stage) and live config registers plus the commit FSM. Writes land
// in the stage copy; the live copy, which drives arbitration, only changes at
// the end-of-frame commit point so a frame is never drawn with mixed config.
// With VGA_LAYER_ARB_BLINK_EN a frame counter and blink phase are added.
//
// Ports:
//   vga_clk, sys_rst_n      pixel clock, async active-low reset
//   pix_x, pix_y            current raster position
//   cfg_wr/addr/wdata       single-cycle config write
//   live                    committed register set
//   cfg_pending             registered: staged write awaiting commit
//   frame_tick              high in the commit-point cycle
//   blink_hide              L2 must be suppressed this frame
// ============================================================================
module vga_layer_cfg
    import vga_layer_pkg::*;
#(
    parameter int H_VALID      = 640,
    parameter int V_VALID      = 480,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        cfg_wr,
    input  logic [2:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    output cfg_regs_t   live,
    output logic        cfg_pending,
    output logic        frame_tick,
    output logic        blink_hide
);

    cfg_state_e state_q, state_d;
    cfg_regs_t  stage_q, stage_d;
    cfg_regs_t  live_q, live_d;
    logic       cfg_pending_q, cfg_pending_d;
    logic       commit_pt;
    logic       wr_ok;

    assign commit_pt = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));
    // Reserved index is a no-op: it neither changes the stage nor arms a commit.
    assign wr_ok     = cfg_wr && (cfg_addr != CFG_RSVD);

    always_comb begin
        state_d = state_q;
        live_d  = live_q;
        stage_d = wr_ok ? cfg_apply(stage_q, cfg_addr, cfg_wdata) : stage_q;
        // live_d copies stage_d (not stage_q) so a write landing on the
        // commit point is part of this frame's commit.
        case (state_q)
            IDLE: begin
                if (wr_ok) begin
                    if (commit_pt) begin
                        state_d = COMMIT;
                        live_d  = stage_d;
                    end else begin
                        state_d = PENDING;
                    end
                end
            end
            PENDING: begin
                if (commit_pt) begin
                    state_d = COMMIT;
                    live_d  = stage_d;
                end
            end
            COMMIT: begin
                // Live was loaded on entry; a write here waits a full frame.
                state_d = wr_ok ? PENDING : IDLE;
            end
            default: state_d = IDLE;
        endcase
        cfg_pending_d = (state_d == PENDING);
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            stage_q       <= CFG_RST;
            live_q        <= CFG_RST;
            cfg_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stage_q       <= stage_d;
            live_q        <= live_d;
            cfg_pending_q <= cfg_pending_d;
        end
    end

    assign live        = live_q;
    assign cfg_pending = cfg_pending_q;
    assign frame_tick  = commit_pt;

`ifdef VGA_LAYER_ARB_BLINK_EN
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (commit_pt) begin
            if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign blink_hide = live_q.en[3] && phase_q;
`else
    assign blink_hide = 1'b0;
`endif

endmodule

// File: rtl/vga_layer_arb.sv
// ============================================================================
// vga_layer_arb
// Per-pixel arbiter between three layers (L0 background pattern, L1 windowed
// overlay, L2 keyed sprite) feeding vga_ctrl. Config is taken from the live
// register set in vga_layer_cfg; output is registered one cycle after
// pix_x/pix_y and forced to black outside the active area.
// Optional feature macro: VGA_LAYER_ARB_BLINK_EN (EN[3] blinks L2 with a
// half-period of BLINK_FRAMES frames).
//
// Ports:
//   vga_clk, sys_rst_n      pixel clock, async active-low reset
//   pix_x, pix_y            raster position (3FF outside active area)
//   l0/l1/l2_data           RGB565 layer pixels aligned to pix_x/pix_y
//   l2_valid                L2 pixel opaque
//   cfg_wr/addr/wdata       config write port
//   cfg_pending             staged write awaiting commit
//   frame_tick              commit-point pulse
//   pix_data                arbitrated RGB565
// ============================================================================
module vga_layer_arb
    import vga_layer_pkg::*;
#(
    parameter int H_VALID      = 640,
    parameter int V_VALID      = 480,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [15:0] l0_data,
    input  logic [15:0] l1_data,
    input  logic [15:0] l2_data,
    input  logic        l2_valid,
    input  logic        cfg_wr,
    input  logic [2:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    output logic        cfg_pending,
    output logic        frame_tick,
    output logic [15:0] pix_data
);

    cfg_regs_t   live;
    logic        blink_hide;
    logic        active, in_win;
    logic        c0, c1, c2;
    logic [15:0] pix_data_q, pix_data_d;

    vga_layer_cfg #(
        .H_VALID      (H_VALID),
        .V_VALID      (V_VALID),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_cfg (
        .vga_clk     (vga_clk),
        .sys_rst_n   (sys_rst_n),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .live        (live),
        .cfg_pending (cfg_pending),
        .frame_tick  (frame_tick),
        .blink_hide  (blink_hide)
    );

    assign active = (pix_x != PIX_INVALID) && (pix_y != PIX_INVALID);
    // Inclusive bounds; X0>X1 or Y0>Y1 can never match, giving an empty window.
    assign in_win = (pix_x >= live.x0) && (pix_x <= live.x1) &&
                    (pix_y >= live.y0) && (pix_y <= live.y1);

    assign c2 = live.en[2] && l2_valid && !blink_hide;
    assign c1 = live.en[1] && in_win;
    assign c0 = live.en[0];

    always_comb begin
        pix_data_d = live.bg;
        if (!active) begin
            pix_data_d = 16'h0000;
        end else if (live.prio) begin
            if (c1)      pix_data_d = l1_data;
            else if (c2) pix_data_d = l2_data;
            else if (c0) pix_data_d = l0_data;
        end else begin
            if (c2)      pix_data_d = l2_data;
            else if (c1) pix_data_d = l1_data;
            else if (c0) pix_data_d = l0_data;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) pix_data_q <= 16'h0000;
        else            pix_data_q <= pix_data_d;
    end

    assign pix_data = pix_data_q;

endmodule

// File: tb/tb_vga_layer_arb.sv
module tb_vga_layer_arb;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n;
    logic [9:0]  pix_x, pix_y;
    logic [15:0] l0_data, l1_data, l2_data;
    logic        l2_valid;
    logic        cfg_wr;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        cfg_pending;
    logic        frame_tick;
    logic [15:0] pix_data;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: register file as plain arrays indexed by address.
    logic [15:0] m_stage [0:6];
    logic [15:0] m_live  [0:6];
    bit          m_pend;
    logic [15:0] exp_pix;
    bit          exp_tick;

    vga_layer_arb dut (
        .vga_clk     (vga_clk),
        .sys_rst_n   (sys_rst_n),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .l0_data     (l0_data),
        .l1_data     (l1_data),
        .l2_data     (l2_data),
        .l2_valid    (l2_valid),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_pending (cfg_pending),
        .frame_tick  (frame_tick),
        .pix_data    (pix_data)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [15:0] reg_mask(input int a);
        case (a)
`ifdef VGA_LAYER_ARB_BLINK_EN
            0:       return 16'h000F;
`else
            0:       return 16'h0007;
`endif
            1:       return 16'hFFFF;
            6:       return 16'h0001;
            default: return 16'h03FF;
        endcase
    endfunction

    task automatic model_reset();
        m_stage[0] = 16'd1; m_stage[1] = 16'd0; m_stage[2] = 16'd1;
        m_stage[3] = 16'd1; m_stage[4] = 16'd0; m_stage[5] = 16'd0;
        m_stage[6] = 16'd0;
        for (int i = 0; i < 7; i++) m_live[i] = m_stage[i];
        m_pend = 0;
    endtask

    // Expected pixel from the priority rules applied to the live registers.
    function automatic logic [15:0] model_pix(input int x, input int y,
                                              input logic [15:0] d0, d1, d2,
                                              input bit v);
        bit s0, s1, s2;
        if (x == 1023 || y == 1023) return 16'h0000;
        s2 = m_live[0][2] && v;
        s1 = m_live[0][1] && x >= int'(m_live[2]) && x <= int'(m_live[4]) &&
             y >= int'(m_live[3]) && y <= int'(m_live[5]);
        s0 = m_live[0][0];
        if (m_live[6][0]) begin
            if (s1) return d1;
            if (s2) return d2;
        end else begin
            if (s2) return d2;
            if (s1) return d1;
        end
        if (s0) return d0;
        return m_live[1];
    endfunction

    // Drive one pixel cycle (called just after a rising edge), advance the
    // model, then return 1 time unit after the next rising edge.
    task automatic step(input logic [9:0] x, input logic [9:0] y,
                        input logic [15:0] d0, input logic [15:0] d1,
                        input logic [15:0] d2, input bit v,
                        input bit wr, input logic [2:0] a, input logic [15:0] wd);
        bit cp, wv;
        pix_x = x; pix_y = y; l0_data = d0; l1_data = d1; l2_data = d2;
        l2_valid = v; cfg_wr = wr; cfg_addr = a; cfg_wdata = wd;
        exp_pix  = model_pix(int'(x), int'(y), d0, d1, d2, v);
        cp       = (x == 10'd639) && (y == 10'd479);
        exp_tick = cp;
        wv       = wr && (a != 3'd7);
        if (wv) m_stage[a] = wd & reg_mask(int'(a));
        if (cp && (m_pend || wv)) begin
            for (int i = 0; i < 7; i++) m_live[i] = m_stage[i];
            m_pend = 0;
        end else if (wv) begin
            m_pend = 1;
        end
        @(posedge vga_clk);
        #1;
        cfg_wr = 1'b0;
    endtask

    task automatic wr_cfg(input logic [2:0] a, input logic [15:0] wd);
        step(10'd40, 10'd40, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b1, a, wd);
    endtask

    task automatic commit_frame();
        step(10'd639, 10'd479, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);
        step(10'h3FF, 10'h3FF, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        pix_x = 10'h3FF; pix_y = 10'h3FF; l0_data = 0; l1_data = 0; l2_data = 0;
        l2_valid = 0; cfg_wr = 0; cfg_addr = 0; cfg_wdata = 0;
        repeat (3) @(posedge vga_clk);
        #1;
        vectors++;
        if (pix_data !== 16'h0000 || cfg_pending !== 1'b0 || frame_tick !== 1'b0) begin
            $display("FAIL reset_state: pix=%h pend=%b tick=%b, want 0/0/0", pix_data, cfg_pending, frame_tick);
            miscompares++;
        end
        sys_rst_n = 1'b1;
        model_reset();
        step(10'd10, 10'd10, 16'hF800, 16'h07E0, 16'h001F, 1'b1, 1'b0, 3'd0, 16'h0);
        vectors++;
        if (pix_data !== 16'hF800) begin
            $display("FAIL reset_l0: pix=%h want F800", pix_data); miscompares++;
        end
        step(10'h3FF, 10'd10, 16'hF800, 16'h0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);
        vectors++;
        if (pix_data !== 16'h0000) begin
            $display("FAIL reset_blank: pix=%h want 0000", pix_data); miscompares++;
        end
    endtask

    task automatic test_window();
        wr_cfg(3'd0, 16'h0007);
        vectors++;
        if (cfg_pending !== 1'b1) begin
            $display("FAIL win_pending: pend=%b want 1", cfg_pending); miscompares++;
        end
        wr_cfg(3'd2, 16'd100); wr_cfg(3'd3, 16'd100);
        wr_cfg(3'd4, 16'd199); wr_cfg(3'd5, 16'd149);
        step(10'd150, 10'd120, 16'hABCD, 16'h07E0, 16'h001F, 1'b1, 1'b0, 3'd0, 16'h0);
        vectors++;
        if (pix_data !== 16'hABCD || cfg_pending !== 1'b1) begin
            $display("FAIL win_precommit: pix=%h pend=%b want ABCD/1", pix_data, cfg_pending); miscompares++;
        end
        step(10'd639, 10'd479, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);
        vectors++;
        if (frame_tick !== 1'b1 || cfg_pending !== 1'b0) begin
            $display("FAIL win_commit: tick=%b pend=%b want 1/0", frame_tick, cfg_pending); miscompares++;
        end
        step(10'h3FF, 10'h3FF, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);
        step(10'd150, 10'd120, 16'hABCD, 16'h07E0, 16'h001F, 1'b0, 1'b0, 3'd0, 16'h0);
        vectors++;
        if (pix_data !== 16'h07E0) begin
            $display("FAIL win_l1: pix=%h want 07E0", pix_data); miscompares++;
        end
        step(10'd150, 10'd120, 16'hABCD, 16'h07E0, 16'h001F, 1'b1, 1'b0, 3'd0, 16'h0);
        vectors++;
        if (pix_data !== 16'h001F) begin
            $display("FAIL win_l2: pix=%h want 001F", pix_data); miscompares++;
        end
        step(10'd200, 10'd120, 16'hABCD, 16'h07E0, 16'h001F, 1'b0, 1'b0, 3'd0, 16'h0);
        vectors++;
        if (pix_data !== 16'hABCD) begin
            $display("FAIL win_outside: pix=%h want ABCD", pix_data); miscompares++;
        end
    endtask

    task automatic test_prio();
        wr_cfg(3'd6, 16'hFFF1);
        commit_frame();
        step(10'd100, 10'd100, 16'hABCD, 16'h07E0, 16'h001F, 1'b1, 1'b0, 3'd0, 16'h0);
        vectors++;
        if (pix_data !== 16'h07E0) begin
            $display("FAIL prio_corner: pix=%h want 07E0", pix_data); miscompares++;
        end
        step(10'd99, 10'd100, 16'hABCD, 16'h07E0, 16'h001F, 1'b1, 1'b0, 3'd0, 16'h0);
        vectors++;
        if (pix_data !== 16'h001F) begin
            $display("FAIL prio_outside: pix=%h want 001F", pix_data); miscompares++;
        end
    endtask

    task automatic test_bg();
        wr_cfg(3'd0, 16'hFFF8);  // EN bits all zero, upper bits ignored
        wr_cfg(3'd1, 16'hFFFF);
        commit_frame();
        for (int i = 0; i < 8; i++) begin
            step(10'($urandom_range(0, 639)), 10'($urandom_range(0, 478)),
                 16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b0, 3'd0, 16'h0);
            vectors++;
            if (pix_data !== 16'hFFFF) begin
                $display("FAIL bg_only[%0d]: pix=%h want FFFF", i, pix_data); miscompares++;
            end
        end
    endtask

    task automatic test_empty_win();
        wr_cfg(3'd0, 16'h0002);
        wr_cfg(3'd1, 16'h5555);
        wr_cfg(3'd2, 16'd300); wr_cfg(3'd4, 16'd200);
        wr_cfg(3'd3, 16'd0);   wr_cfg(3'd5, 16'd479);
        commit_frame();
        for (int i = 0; i < 8; i++) begin
            step(10'($urandom_range(150, 350)), 10'($urandom_range(0, 478)),
                 16'h1111, 16'hAAAA, 16'h3333, 1'b1, 1'b0, 3'd0, 16'h0);
            vectors++;
            if (pix_data !== 16'h5555) begin
                $display("FAIL empty_win[%0d]: pix=%h want 5555", i, pix_data); miscompares++;
            end
        end
    endtask

    task automatic test_coincident();
        step(10'd639, 10'd479, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 3'd1, 16'h1357);
        vectors++;
        if (cfg_pending !== 1'b0 || frame_tick !== 1'b1) begin
            $display("FAIL coinc_pend: pend=%b tick=%b want 0/1", cfg_pending, frame_tick); miscompares++;
        end
        step(10'h3FF, 10'h3FF, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);
        step(10'd5, 10'd5, 16'h1111, 16'h2222, 16'h3333, 1'b1, 1'b0, 3'd0, 16'h0);
        vectors++;
        if (pix_data !== 16'h1357) begin
            $display("FAIL coinc_commit: pix=%h want 1357", pix_data); miscompares++;
        end
    endtask

    task automatic test_commit_cycle_wr();
        wr_cfg(3'd1, 16'h2468);
        step(10'd639, 10'd479, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);
        step(10'h3FF, 10'h3FF, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 3'd1, 16'h9999);
        vectors++;
        if (cfg_pending !== 1'b1) begin
            $display("FAIL cc_wr_pend: pend=%b want 1", cfg_pending); miscompares++;
        end
        for (int i = 0; i < 20; i++) begin
            step(10'($urandom_range(0, 639)), 10'($urandom_range(0, 478)),
                 16'h1111, 16'h2222, 16'h3333, 1'b1, 1'b0, 3'd0, 16'h0);
            vectors++;
            if (pix_data !== 16'h2468 || cfg_pending !== 1'b1) begin
                $display("FAIL cc_hold[%0d]: pix=%h pend=%b want 2468/1", i, pix_data, cfg_pending); miscompares++;
            end
        end
        commit_frame();
        step(10'd7, 10'd7, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 3'd0, 16'h0);
        vectors++;
        if (pix_data !== 16'h9999 || cfg_pending !== 1'b0) begin
            $display("FAIL cc_next: pix=%h pend=%b want 9999/0", pix_data, cfg_pending); miscompares++;
        end
    endtask

    task automatic test_random();
        bit last_cp = 0;
        for (int i = 0; i < 400; i++) begin
            logic [9:0]  x, y;
            logic [15:0] wd;
            logic [2:0]  a;
            bit          wr;
            if (!last_cp && $urandom_range(0, 19) == 0) begin
                x = 10'd639; y = 10'd479;
            end else begin
                x = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 639));
                y = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 479));
                if (x == 10'd639 && y == 10'd479) y = 10'd478;
            end
            last_cp = (x == 10'd639 && y == 10'd479);
            wr = ($urandom_range(0, 3) == 0);
            a  = 3'($urandom_range(0, 7));
            wd = 16'($urandom);
            if (a >= 3'd2 && a <= 3'd5) wd[9:0] = 10'($urandom_range(0, 500));
            if (a == 3'd0) wd[3] = 1'b0;
            step(x, y, 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                 wr, a, wd);
            vectors++;
            if (pix_data !== exp_pix || cfg_pending !== m_pend || frame_tick !== exp_tick) begin
                $display("FAIL random[%0d]: pix=%h pend=%b tick=%b want %h/%b/%b",
                         i, pix_data, cfg_pending, frame_tick, exp_pix, m_pend, exp_tick);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset_mid();
        wr_cfg(3'd0, 16'h0004);
        step(10'd60, 10'd60, 16'h4444, 16'h0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);
        #2;
        sys_rst_n = 1'b0;
        #1;
        vectors++;
        if (pix_data !== 16'h0000 || cfg_pending !== 1'b0) begin
            $display("FAIL rst_mid: pix=%h pend=%b want 0000/0", pix_data, cfg_pending); miscompares++;
        end
        @(posedge vga_clk);
        #1;
        sys_rst_n = 1'b1;
        model_reset();
        commit_frame();
        step(10'd20, 10'd20, 16'hA5A5, 16'h0, 16'h5A5A, 1'b1, 1'b0, 3'd0, 16'h0);
        vectors++;
        if (pix_data !== 16'hA5A5 || cfg_pending !== 1'b0) begin
            $display("FAIL rst_live_en: pix=%h pend=%b want A5A5/0", pix_data, cfg_pending); miscompares++;
        end
    endtask

    initial begin
        model_reset();
        exp_pix  = 16'h0;
        exp_tick = 0;
        test_reset();
        test_window();
        test_prio();
        test_bg();
        test_empty_win();
        test_coincident();
        test_commit_cycle_wr();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
